booth_seq_mult: RTL and testbench
=================================

// Module: booth_seq_mult
// PURPOSE
//  Multi-cycle radix-2 Booth signed multiplier for the EX stage; the producer end of the
//  EX result select: its product is what the 32-bit 2:1 result mux picks over the ALU
//  output when select=1. One signed WIDTHxWIDTH multiply per start, a 2*WIDTH product
//  split into HI/LO. The hazard unit stalls the pipeline while busy=1.
// PARAMETERS
//  WIDTH   32   operand width; product is 2*WIDTH (must be >=2)
// PORTS
//  clk            in   1        single clock, all state on rising edge
//  rst            in   1        synchronous reset, active-high
//  start          in   1        request; sampled only in IDLE
//  multiplicand   in   WIDTH    signed operand M (rs)
//  multiplier     in   WIDTH    signed operand Q (rt)
//  busy           out  1        1 while iterating
//  done           out  1        1-cycle pulse: result_hi/lo valid
//  result_hi      out  WIDTH    product[2W-1:W] (HI)
//  result_lo      out  WIDTH    product[W-1:0]  (LO)
// BEHAVIOUR
//  Reset: synchronous, active-high; overrides everything, aborts any operation.
//   state=IDLE; busy=0, done=0, result_hi=0, result_lo=0; internal regs 0.
//  FSM: IDLE, RUN.
//   IDLE & start @edge k: latch M; A(acc, WIDTH+1 bits)=0; Qreg=multiplier;
//   q_1=0; cnt=WIDTH; ->RUN. busy=1 from k.
//   IDLE & !start: hold; outputs keep their last product.
//   RUN, each edge: one Booth step on {Qreg[0],q_1}:
//   01 -> A=A+sext(M); 10 -> A=A-sext(M); 00/11 -> no add.
//   Then arithmetic shift right {A,Qreg,q_1} by 1; cnt=cnt-1.
//   The step at which cnt==1 is the last: ->IDLE, busy=0, done=1 for one cycle,
//   result_hi=A[WIDTH-1:0] after the shift, result_lo=Qreg after the shift.
//  Latency: start edge k -> done high in the cycle after edge k+WIDTH (WIDTH steps).
//  busy is high for exactly WIDTH cycles. done and busy are never both 1.
//  Arithmetic: A is WIDTH+1 bits so that subtracting M=-2^(WIDTH-1) cannot overflow.
//  Operands are two's-complement signed only. An unsigned multiply (multu) is
//  decoded elsewhere and does not use this block.
//  Operand inputs are ignored except at the accepting edge; they may change while busy.
//  start while busy: ignored, not queued.
//  start in the done cycle: accepted (FSM is in IDLE). Next busy begins at that edge.
//  result_hi/lo hold the product until the next op completes. They do not change
//  while a new op runs.
//  Reset during RUN: the op is discarded, outputs are cleared, and no done is issued.
// TESTING
//  1 M=3, Q=-5, start 1 cycle -> busy 32 cycles; done pulse; HI=FFFFFFFF LO=FFFFFFF1.
//  2 M=80000000, Q=80000000 -> HI=40000000, LO=00000000 (no acc overflow).
//  3 M=80000000, Q=FFFFFFFF -> HI=00000000, LO=80000000 (+2^31).
//  4 start M=7,Q=6, pulse start again with M=2,Q=2 at busy cycle 5 -> ignored;
//    single done after 32 cycles with LO=0000002A. Previous result held until then.
//  5 rst=1 at busy cycle 10 -> next cycle busy=0 done=0 HI=LO=0, and no done is issued.
//    Then M=-1,Q=-1 -> LO=00000001 HI=0.
//  6 back-to-back: start held high through done -> new op accepted in the done cycle.
//    Run 1000 random signed pairs with checks against $signed(M)*$signed(Q) and
//    busy/done timing.

Source files
------------

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth signed multiplier: one WIDTHxWIDTH product per start,
// WIDTH iteration cycles, result split into HI/LO words that hold until the next op completes.
module booth_seq_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH-1:0]   qreg_q, qreg_d;
    logic               q1_q, q1_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     sum;

    // The extra accumulator bit keeps A - (-2^(WIDTH-1)) representable.
    assign m_ext = {m_q[WIDTH-1], m_q};

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        qreg_d  = qreg_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sum     = a_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = multiplicand;
                    a_d     = '0;
                    qreg_d  = multiplier;
                    q1_d    = 1'b0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                case ({qreg_q[0], q1_q})
                    2'b01:   sum = a_q + m_ext;
                    2'b10:   sum = a_q - m_ext;
                    default: sum = a_q;
                endcase
                // Arithmetic right shift of the concatenation {A, Qreg, q_1}.
                a_d    = {sum[WIDTH], sum[WIDTH:1]};
                qreg_d = {sum[0], qreg_q[WIDTH-1:1]};
                q1_d   = qreg_q[0];
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    hi_d    = a_d[WIDTH-1:0];
                    lo_d    = qreg_d;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            a_q     <= '0;
            qreg_q  <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            qreg_q  <= qreg_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = done_q;
    assign result_hi = hi_q;
    assign result_lo = lo_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and random checks of booth_seq_mult: products, busy/done timing,
// ignored restarts, reset abort and back-to-back acceptance in the done cycle.
module tb_booth_seq_mult;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] result_hi;
    logic [31:0] result_lo;

    int          tests_run  = 0;
    int          fail_count = 0;
    logic [63:0] last_exp   = 64'd0;

    booth_seq_mult #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .result_hi    (result_hi),
        .result_lo    (result_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one op; optionally pulses a second start at busy cycle inject_at.
    task automatic applyStimulus(input logic [31:0] m, input logic [31:0] q,
                                 input logic [63:0] exp, input int inject_at, input string tag);
        int   n;
        logic saw_done;
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        n        = 0;
        saw_done = 1'b0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (done !== 1'b0) saw_done = 1'b1;
            if (n == 16) checkOutput({tag, "_held"}, {result_hi, result_lo}, last_exp);
            if (n == inject_at) begin
                start        = 1'b1;
                multiplicand = 32'd2;
                multiplier   = 32'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput({tag, "_busy_cycles"}, 64'(n), 64'd32);
        checkOutput({tag, "_no_early_done"}, {63'd0, saw_done}, 64'd0);
        checkOutput({tag, "_done"}, {63'd0, done}, 64'd1);
        checkOutput({tag, "_product"}, {result_hi, result_lo}, exp);
        last_exp = exp;
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        int          n;
        logic        saw_done;
        logic [31:0] rm, rq;
        logic [63:0] rexp;

        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = 32'd0;
        multiplier   = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", {30'd0, busy, done, result_hi, result_lo}, 64'd0);
        rst = 1'b0;

        applyStimulus(32'd3,        32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, -1, "t1_3x-5");
        applyStimulus(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, -1, "t2_min_sq");
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, -1, "t3_min_neg1");
        applyStimulus(32'd7,        32'd6,         64'h0000_0000_0000_002A,  5, "t4_restart");

        // Reset in the middle of an op: outputs clear and no done follows.
        @(negedge clk);
        multiplicand = 32'd11;
        multiplier   = 32'd13;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t5_reset_abort", {30'd0, busy, done, result_hi, result_lo}, 64'd0);
        rst      = 1'b0;
        last_exp = 64'd0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        checkOutput("t5_no_done_after_reset", {63'd0, saw_done}, 64'd0);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, -1, "t5_neg1_sq");

        // Start held high: second op is accepted at the edge ending the done cycle.
        @(negedge clk);
        multiplicand = 32'd5;
        multiplier   = 32'hFFFF_FFFD;
        start        = 1'b1;
        @(negedge clk);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkOutput("t6_first_busy_cycles", 64'(n), 64'd32);
        checkOutput("t6_first_done", {63'd0, done}, 64'd1);
        checkOutput("t6_first_product", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        multiplicand = 32'hFFFF_FFF9;
        multiplier   = 32'd9;
        @(negedge clk);
        checkOutput("t6_accept_in_done", {62'd0, busy, done}, 64'd2);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkOutput("t6_second_busy_cycles", 64'(n), 64'd32);
        checkOutput("t6_second_done", {63'd0, done}, 64'd1);
        checkOutput("t6_second_product", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFC1);
        last_exp = 64'hFFFF_FFFF_FFFF_FFC1;
        @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            rm   = $urandom;
            rq   = $urandom;
            rexp = 64'(longint'($signed(rm)) * longint'($signed(rq)));
            applyStimulus(rm, rq, rexp, -1, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
